exp2_x: RTL and testbench
=========================

EXP2_X -- requirements
Module: exp2_x

Interface
REQ-001 Parameter DATA_WIDTH, 32, FP32 word width.
REQ-002 Parameter EXPO_WIDTH, 8, exponent field width.
REQ-003 Parameter MANT_WIDTH, 23, mantissa field width.
REQ-004 Parameter LUT_SIZE, 32, number of interpolation segments over [0,1).
REQ-005 Parameter LUT_BITS, 17, table entry width (unsigned, 1.0 encoded as 65536).
REQ-006 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 en  input  1  pipeline advance enable; when 0, all registers SHALL hold.
REQ-009 vld_in  input  1  Oprand_A valid this cycle.
REQ-010 Oprand_A  input  DATA_WIDTH  FP32 operand x.
REQ-011 Result  output  DATA_WIDTH  FP32 result 2^x, registered.
REQ-012 vld_out  output  1  Result valid, registered.

Function
REQ-013 Block SHALL compute Result = 2^x, the inverse of the team's log2 unit, using Result bit layout {sign, exponent, mantissa}.
REQ-014 Latency SHALL be exactly 5 en-high cycles from vld_in sample to vld_out; throughput one operand per en-high cycle, no back-pressure other than en.
REQ-015 Stages: S0 input register; S1 classify and convert to fixed point; S2 synchronous LUT read of T[n], T[n+1]; S3 multiply-add; S4 pack into Result register.
REQ-016 Valid bit SHALL travel with data through all 5 stages; with en=0 the input is not sampled, vld_in is ignored, and no valid is created or lost.
REQ-017 Conversion: e=exponent field; if 103<=e<=133, |x| SHALL be formed as unsigned Q8.23 {1,mant} shifted by (e-127); negative x SHALL be two's-complement negated so that x = I + F, I = floor(x) signed, F in [0,1) as 23-bit fraction.
REQ-018 Interpolation: n = F[22:18], r = F[17:0]; frac = T[n] + (((T[n+1]-T[n]) * r) >> 18), truncating; frac SHALL fit 16 bits.
REQ-019 Table: T[k] = round(65536*(2^(k/32)-1)) for k=0..32, T[0]=0, T[32]=65536; read-only, write ports tied off.
REQ-020 Normal output: sign 0, exponent I+127, mantissa {frac[15:0], 7'b0}; F=0 SHALL give mantissa 0 exactly.
REQ-021 Special cases (priority order): NaN -> 0x7FC00000; +inf -> 0x7F800000; -inf -> 0x00000000; e<103 (incl. zero, subnormal) -> 0x3F800000; I+127>254 -> 0x7F800000; I+127<1 -> 0x00000000 (no subnormal output).
REQ-022 Special-case flags SHALL be pipelined alongside data and override packing in S4.
REQ-023 Output sign SHALL always be 0 except never; NaN payload SHALL not propagate.

Reset
REQ-024 rst=1 at a rising edge SHALL clear every pipeline register; Result=0x00000000, vld_out=0 on the following cycle.
REQ-025 rst SHALL override en; reset mid-operation SHALL discard all in-flight operands, none emerge afterward.
REQ-026 First operand after reset release SHALL appear 5 en-high cycles later with correct value.

Verification
REQ-027 x=0x40400000 (3.0), en=1 -> Result=0x41000000, vld_out 5 cycles later; x=0xBF800000 (-1.0) -> 0x3F000000.
REQ-028 x=0x3F000000 (0.5) -> 0x3FB50500; x=0xBF000000 (-0.5) -> 0x3F350500.
REQ-029 Specials: 0x7FC00001 -> 0x7FC00000; 0xFF800000 -> 0; 0x43000000 (128.0) -> 0x7F800000; 0xC3000000 (-128.0) -> 0; 0x00000000 -> 0x3F800000.
REQ-030 Stream 10 back-to-back operands, drop en for 3 cycles mid-stream -> outputs in order, identical values, Result/vld_out frozen while en=0.
REQ-031 Assert rst with 4 operands in flight -> vld_out=0, Result=0 next cycle, no stale outputs after release.
REQ-032 Random sweep of 10^5 finite inputs in [-126,128) vs. reference model of REQ-017..021 -> bit-exact; vs. real 2^x relative error < 2^-14.

Source files
------------

// File: rtl/exp2_x.sv
// exp2_x: five-stage pipelined FP32 base-2 exponential, Result = 2^x.
// It is the inverse of the log2 unit. It splits x into I + F, with I = floor(x).
// 2^F - 1 is approximated by linear interpolation over a 33-entry table,
// which gives the mantissa. I + 127 becomes the exponent.
//
// Ports
//   clk      : single clock, everything updates on its rising edge
//   rst      : synchronous active-high reset, overrides en
//   en       : pipeline advance enable; all registers hold while low
//   vld_in   : Oprand_A carries an operand this cycle
//   Oprand_A : FP32 operand x
//   Result   : FP32 result 2^x (registered)
//   vld_out  : Result valid (registered)
//
// Stages
//   S0 input register
//   S1 classify + fixed-point conversion
//   S2 table read
//   S3 multiply-add
//   S4 pack
module exp2_x #(
    parameter int DATA_WIDTH = 32,
    parameter int EXPO_WIDTH = 8,
    parameter int MANT_WIDTH = 23,
    parameter int LUT_SIZE   = 32,
    parameter int LUT_BITS   = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  vld_in,
    input  logic [DATA_WIDTH-1:0] Oprand_A,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  vld_out
);

    localparam int BIAS       = (1 << (EXPO_WIDTH - 1)) - 1;
    localparam int IDX_W      = $clog2(LUT_SIZE);
    localparam int R_W        = MANT_WIDTH - IDX_W;
    // Fixed-point x: sign + 8 integer bits + MANT_WIDTH fraction bits.
    localparam int FIX_W      = MANT_WIDTH + 9;
    localparam int MAG_W      = FIX_W - 1;
    localparam int FRAC_OUT_W = LUT_BITS - 1;
    localparam int PROD_W     = LUT_BITS + R_W;

    localparam logic [EXPO_WIDTH-1:0] E_BIAS = EXPO_WIDTH'(BIAS);
    // Below 2^-24 the fraction underflows to zero, so the result is 1.0.
    localparam logic [EXPO_WIDTH-1:0] E_MIN  = EXPO_WIDTH'(BIAS - MANT_WIDTH - 1);
    // At 2^7 and above, |x| >= 128 always saturates.
    localparam logic [EXPO_WIDTH-1:0] E_MAX  = EXPO_WIDTH'(BIAS + 6);
    localparam logic [EXPO_WIDTH-1:0] E_ALL1 = '1;

    localparam logic [DATA_WIDTH-1:0] QNAN_W = DATA_WIDTH'(32'h7FC0_0000);
    localparam logic [DATA_WIDTH-1:0] PINF_W = DATA_WIDTH'(32'h7F80_0000);
    localparam logic [DATA_WIDTH-1:0] ONE_W  = DATA_WIDTH'(32'h3F80_0000);
    localparam logic [IDX_W:0]        IDX_ONE = (IDX_W + 1)'(1);

    typedef enum logic [2:0] {
        CLS_NORM,
        CLS_NAN,
        CLS_PINF,
        CLS_ZERO,
        CLS_ONE
    } cls_t;

    // T[k] = round(65536 * (2^(k/32) - 1)). This is a read-only table.
    function automatic logic [LUT_BITS-1:0] lut_rd(input logic [IDX_W:0] k);
        case (k)
            6'd0:    lut_rd = LUT_BITS'(0);
            6'd1:    lut_rd = LUT_BITS'(1435);
            6'd2:    lut_rd = LUT_BITS'(2902);
            6'd3:    lut_rd = LUT_BITS'(4400);
            6'd4:    lut_rd = LUT_BITS'(5932);
            6'd5:    lut_rd = LUT_BITS'(7496);
            6'd6:    lut_rd = LUT_BITS'(9096);
            6'd7:    lut_rd = LUT_BITS'(10730);
            6'd8:    lut_rd = LUT_BITS'(12400);
            6'd9:    lut_rd = LUT_BITS'(14106);
            6'd10:   lut_rd = LUT_BITS'(15850);
            6'd11:   lut_rd = LUT_BITS'(17633);
            6'd12:   lut_rd = LUT_BITS'(19454);
            6'd13:   lut_rd = LUT_BITS'(21315);
            6'd14:   lut_rd = LUT_BITS'(23216);
            6'd15:   lut_rd = LUT_BITS'(25160);
            6'd16:   lut_rd = LUT_BITS'(27146);
            6'd17:   lut_rd = LUT_BITS'(29175);
            6'd18:   lut_rd = LUT_BITS'(31249);
            6'd19:   lut_rd = LUT_BITS'(33369);
            6'd20:   lut_rd = LUT_BITS'(35534);
            6'd21:   lut_rd = LUT_BITS'(37747);
            6'd22:   lut_rd = LUT_BITS'(40009);
            6'd23:   lut_rd = LUT_BITS'(42320);
            6'd24:   lut_rd = LUT_BITS'(44682);
            6'd25:   lut_rd = LUT_BITS'(47095);
            6'd26:   lut_rd = LUT_BITS'(49562);
            6'd27:   lut_rd = LUT_BITS'(52082);
            6'd28:   lut_rd = LUT_BITS'(54658);
            6'd29:   lut_rd = LUT_BITS'(57289);
            6'd30:   lut_rd = LUT_BITS'(59979);
            6'd31:   lut_rd = LUT_BITS'(62727);
            default: lut_rd = LUT_BITS'(65536);
        endcase
    endfunction

    // Pipeline registers
    logic [DATA_WIDTH-1:0] s0_x;
    logic                  s0_v;

    cls_t                  s1_cls;
    logic                  s1_v;
    logic [EXPO_WIDTH-1:0] s1_exp;
    logic [IDX_W-1:0]      s1_idx;
    logic [R_W-1:0]        s1_r;

    cls_t                  s2_cls;
    logic                  s2_v;
    logic [EXPO_WIDTH-1:0] s2_exp;
    logic [LUT_BITS-1:0]   s2_t0;
    logic [LUT_BITS-1:0]   s2_t1;
    logic [R_W-1:0]        s2_r;

    cls_t                  s3_cls;
    logic                  s3_v;
    logic [EXPO_WIDTH-1:0] s3_exp;
    logic [FRAC_OUT_W-1:0] s3_frac;

    // S1 combinational: classify and convert to fixed point
    logic                  in_sgn;
    logic [EXPO_WIDTH-1:0] in_exp;
    logic [MANT_WIDTH-1:0] in_man;
    logic [MAG_W-1:0]      mag;
    logic signed [FIX_W-1:0] fx;
    logic signed [8:0]     int_part;
    logic signed [9:0]     biased;
    cls_t                  cls_c;

    assign in_sgn = s0_x[DATA_WIDTH-1];
    assign in_exp = s0_x[DATA_WIDTH-2 -: EXPO_WIDTH];
    assign in_man = s0_x[MANT_WIDTH-1:0];

    always_comb begin
        mag = {{(MAG_W - MANT_WIDTH - 1){1'b0}}, 1'b1, in_man};
        if (in_exp >= E_BIAS) begin
            mag = mag << (in_exp - E_BIAS);
        end else begin
            mag = mag >> (E_BIAS - in_exp);
        end

        // A negative x is negated in two's complement. The top bits are then
        // floor(x), and the low bits are the non-negative fraction.
        if (in_sgn) begin
            fx = -$signed({1'b0, mag});
        end else begin
            fx = $signed({1'b0, mag});
        end
        int_part = fx[FIX_W-1:MANT_WIDTH];
        biased   = {int_part[8], int_part} + 10'(BIAS);

        if (in_exp == E_ALL1 && in_man != '0) begin
            cls_c = CLS_NAN;
        end else if (in_exp == E_ALL1) begin
            cls_c = in_sgn ? CLS_ZERO : CLS_PINF;
        end else if (in_exp < E_MIN) begin
            cls_c = CLS_ONE;
        end else if (in_exp > E_MAX) begin
            cls_c = in_sgn ? CLS_ZERO : CLS_PINF;
        end else if (biased > 10'sd254) begin
            cls_c = CLS_PINF;
        end else if (biased < 10'sd1) begin
            cls_c = CLS_ZERO;
        end else begin
            cls_c = CLS_NORM;
        end
    end

    // S3 combinational: interpolation product
    logic [LUT_BITS-1:0] diff;
    logic [PROD_W-1:0]   prod;

    always_comb begin
        diff = s2_t1 - s2_t0;
        prod = {{R_W{1'b0}}, diff} * {{LUT_BITS{1'b0}}, s2_r};
    end

    // S4 combinational: special-case override, otherwise normal pack
    logic [DATA_WIDTH-1:0] pack_c;

    always_comb begin
        pack_c = '0;
        case (s3_cls)
            CLS_NAN:  pack_c = QNAN_W;
            CLS_PINF: pack_c = PINF_W;
            CLS_ONE:  pack_c = ONE_W;
            CLS_ZERO: pack_c = '0;
            default:  pack_c = {1'b0, s3_exp, s3_frac,
                                {(MANT_WIDTH - FRAC_OUT_W){1'b0}}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_x    <= '0;
            s0_v    <= 1'b0;
            s1_cls  <= CLS_ZERO;
            s1_v    <= 1'b0;
            s1_exp  <= '0;
            s1_idx  <= '0;
            s1_r    <= '0;
            s2_cls  <= CLS_ZERO;
            s2_v    <= 1'b0;
            s2_exp  <= '0;
            s2_t0   <= '0;
            s2_t1   <= '0;
            s2_r    <= '0;
            s3_cls  <= CLS_ZERO;
            s3_v    <= 1'b0;
            s3_exp  <= '0;
            s3_frac <= '0;
            Result  <= '0;
            vld_out <= 1'b0;
        end else if (en) begin
            // S0
            s0_x    <= Oprand_A;
            s0_v    <= vld_in;
            // S1
            s1_cls  <= cls_c;
            s1_v    <= s0_v;
            s1_exp  <= biased[EXPO_WIDTH-1:0];
            s1_idx  <= fx[MANT_WIDTH-1 -: IDX_W];
            s1_r    <= fx[R_W-1:0];
            // S2
            s2_cls  <= s1_cls;
            s2_v    <= s1_v;
            s2_exp  <= s1_exp;
            s2_t0   <= lut_rd({1'b0, s1_idx});
            s2_t1   <= lut_rd({1'b0, s1_idx} + IDX_ONE);
            s2_r    <= s1_r;
            // S3: T[n+1] bounds the sum, so it always fits FRAC_OUT_W bits
            s3_cls  <= s2_cls;
            s3_v    <= s2_v;
            s3_exp  <= s2_exp;
            s3_frac <= FRAC_OUT_W'(s2_t0 + LUT_BITS'(prod >> R_W));
            // S4
            Result  <= pack_c;
            vld_out <= s3_v;
        end
    end

endmodule

// File: tb/tb_exp2_x.sv
module tb_exp2_x;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        vld_in = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] result;
    logic        vld_out;

    always #5 clk = ~clk;

    exp2_x #(
        .DATA_WIDTH(32),
        .EXPO_WIDTH(8),
        .MANT_WIDTH(23),
        .LUT_SIZE(32),
        .LUT_BITS(17)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .vld_in(vld_in),
        .Oprand_A(opa),
        .Result(result),
        .vld_out(vld_out)
    );

    int   errors = 0;
    int   checks = 0;
    int   tab[0:32];
    bit   armed = 1'b0;
    logic        exp_v[0:4];
    logic [31:0] exp_r[0:4];

    // Reference 2^x: floor-split x = I + F from the real value of x
    function automatic logic [31:0] model(input logic [31:0] x);
        bit     sgn;
        int     e;
        int     m;
        real    mag_r;
        longint fx;
        longint i;
        longint f;
        longint n;
        longint r;
        longint frac;
        sgn = x[31];
        e   = int'(x[30:23]);
        m   = int'(x[22:0]);
        if (e == 255 && m != 0) return 32'h7FC00000;
        if (e == 255) return sgn ? 32'h0 : 32'h7F800000;
        if (e < 103) return 32'h3F800000;
        if (e > 133) return sgn ? 32'h0 : 32'h7F800000;
        mag_r = (1.0 + real'(m) / 8388608.0) * (2.0 ** real'(e - 127));
        fx = longint'($floor(mag_r * 8388608.0));
        if (sgn) fx = -fx;
        i = fx >>> 23;
        f = fx & 64'h7FFFFF;
        if (i + 127 > 254) return 32'h7F800000;
        if (i + 127 < 1) return 32'h0;
        n = f >>> 18;
        r = f & 64'h3FFFF;
        frac = longint'(tab[n]) + (((longint'(tab[n + 1]) - longint'(tab[n])) * r) >>> 18);
        return {1'b0, 8'(i + 127), 16'(frac), 7'b0};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, req, $time);
        end
    endtask

    // Latency line: an operand sampled on an en-high edge appears 5 en-high edges later
    initial begin
        for (int i = 0; i < 5; i++) begin
            exp_v[i] = 1'b0;
            exp_r[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) exp_v[i] <= 1'b0;
        end else if (en) begin
            exp_v[0] <= vld_in;
            exp_r[0] <= model(opa);
            for (int i = 1; i < 5; i++) begin
                exp_v[i] <= exp_v[i - 1];
                exp_r[i] <= exp_r[i - 1];
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check32("vld_out", {31'b0, vld_out}, {31'b0, exp_v[4]});
            if (exp_v[4]) check32("result", result, exp_r[4]);
        end
    end

    task automatic step(input logic e_i, input logic v_i, input logic [31:0] x_i);
        en = e_i;
        vld_in = v_i;
        opa = x_i;
        @(negedge clk);
    endtask

    task automatic latency_test(input logic [31:0] x, input logic [31:0] want, input string name);
        int cnt;
        step(1'b1, 1'b1, x);
        cnt = 1;
        while (vld_out !== 1'b1 && cnt < 20) begin
            step(1'b1, 1'b0, 32'h0);
            cnt++;
        end
        check32({name, "_latency"}, 32'(cnt), 32'd5);
        check32({name, "_value"}, result, want);
        step(1'b1, 1'b0, 32'h0);
    endtask

    logic [31:0] dir_x[12];
    logic [31:0] dir_w[12];
    logic [31:0] bnd_x[10];
    logic [31:0] got[$];
    logic [31:0] held;
    int          stale;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k <= 32; k++)
            tab[k] = $rtoi($floor(65536.0 * (2.0 ** (real'(k) / 32.0) - 1.0) + 0.5));

        dir_x = '{32'h40400000, 32'hBF800000, 32'h3F000000, 32'hBF000000,
                  32'h7FC00001, 32'hFF800000, 32'h43000000, 32'hC3000000,
                  32'h00000000, 32'hC2FC0000, 32'h3D000000, 32'h3F040000};
        dir_w = '{32'h41000000, 32'h3F000000, 32'h3FB50500, 32'h3F350500,
                  32'h7FC00000, 32'h00000000, 32'h7F800000, 32'h00000000,
                  32'h3F800000, 32'h00800000, 32'h3F82CD80, 32'h3FB70000};
        bnd_x = '{32'hC2FC0000, 32'hC2FE0000, 32'h42FE0000, 32'h42FF0000, 32'hC2FD0000,
                  32'h33000000, 32'h33800000, 32'hB3800000, 32'h00000001, 32'h80000000};

        // Pin the reference model to hand-computed results
        for (int i = 0; i < 12; i++) check32("model_pin", model(dir_x[i]), dir_w[i]);

        // Reset state
        rst = 1'b1;
        en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        armed = 1'b1;
        check32("reset_result", result, 32'h0);
        check32("reset_vld", {31'b0, vld_out}, 32'h0);
        rst = 1'b0;

        // Single operand: exact latency and value
        latency_test(32'h40400000, 32'h41000000, "lat_3p0");

        // Directed vectors back-to-back, outputs compared to literals in order
        got.delete();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, dir_x[i]);
            if (vld_out) got.push_back(result);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (vld_out) got.push_back(result);
        end
        check32("dir_count", 32'(got.size()), 32'd12);
        for (int i = 0; i < 12; i++)
            if (i < got.size()) check32("dir_value", got[i], dir_w[i]);

        // Ten operands with en dropped for three cycles mid-stream
        for (int i = 0; i < 10; i++) begin
            if (i == 7) begin
                held = result;
                for (int j = 0; j < 3; j++) begin
                    step(1'b0, 1'b1, 32'h7FC00001);
                    check32("freeze_result", result, held);
                    check32("freeze_vld", {31'b0, vld_out}, 32'h1);
                end
            end
            step(1'b1, 1'b1, 32'h3E000000 + (32'(i) << 19));
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);

        // Reset with four operands in flight
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, dir_x[i]);
        rst = 1'b1;
        step(1'b1, 1'b1, 32'h40400000);
        check32("rst_flight_result", result, 32'h0);
        check32("rst_flight_vld", {31'b0, vld_out}, 32'h0);
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 32'h40400000);
            if (vld_out) stale++;
        end
        check32("no_stale", 32'(stale), 32'd0);
        latency_test(32'h3F000000, 32'h3FB50500, "lat_after_rst");

        // Random sweep with en and valid gaps
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] x;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) x = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 102)), 23'($urandom)};
            else if (sel == 1) x = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(0, 3))};
            else if (sel == 2) x = bnd_x[$urandom_range(0, 9)];
            else x = {1'($urandom_range(0, 1)), 8'($urandom_range(103, 133)), 23'($urandom)};
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0), x);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
